// File: rtl/region_interconnect.sv
// region_interconnect: one data master to REGIONS base/end-decoded slaves with req/ack handshake.
// Optional macro REGION_INTERCONNECT_TIMEOUT_EN: abandon ACCESS with an error after TIMEOUT unacknowledged cycles.
module region_interconnect #(
    parameter int unsigned REGIONS = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [REGIONS*ADDR_W-1:0]   region_base,
    input  logic [REGIONS*ADDR_W-1:0]   region_end,
    input  logic                        req_m,
    input  logic                        we_m,
    input  logic [ADDR_W-1:0]           addr_m,
    input  logic [DATA_W-1:0]           wd_m,
    input  logic [DATA_W/8-1:0]         be_m,
    output logic                        ready_m,
    output logic                        err_m,
    output logic [DATA_W-1:0]           rd_m,
    output logic [REGIONS-1:0]          req_s,
    output logic [REGIONS-1:0]          we_s,
    output logic [ADDR_W-1:0]           addr_s,
    output logic [DATA_W-1:0]           wd_s,
    output logic [DATA_W/8-1:0]         be_s,
    input  logic [REGIONS-1:0]          ack_s,
    input  logic [REGIONS*DATA_W-1:0]   rd_s
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned SEL_W = (REGIONS > 1) ? $clog2(REGIONS) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wd_q, wd_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   rd_q, rd_d;

`ifdef REGION_INTERCONNECT_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    logic                hit;
    logic [SEL_W-1:0]    hit_idx;
    logic [ADDR_W-1:0]   hit_base;

    // First matching region wins, so lower indices take priority on overlap.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_base = '0;
        for (int unsigned i = 0; i < REGIONS; i++) begin
            if (!hit && addr_m >= region_base[i*ADDR_W +: ADDR_W]
                     && addr_m <  region_end[i*ADDR_W +: ADDR_W]) begin
                hit      = 1'b1;
                hit_idx  = SEL_W'(i);
                hit_base = region_base[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        be_d    = be_q;
        rd_d    = rd_q;
`ifdef REGION_INTERCONNECT_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_m) begin
                    if (hit) begin
                        sel_d   = hit_idx;
                        we_d    = we_m;
                        addr_d  = addr_m - hit_base;
                        wd_d    = wd_m;
                        be_d    = be_m;
                        state_d = ACCESS;
`ifdef REGION_INTERCONNECT_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        rd_d    = '0;
                        state_d = ERR;
                    end
                end
            end
            ACCESS: begin
                if (ack_s[sel_q]) begin
                    rd_d    = we_q ? '0 : rd_s[sel_q*DATA_W +: DATA_W];
                    state_d = RESP;
                end
`ifdef REGION_INTERCONNECT_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rd_d    = '0;
                    state_d = ERR;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            be_q    <= '0;
            rd_q    <= '0;
`ifdef REGION_INTERCONNECT_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
`ifdef REGION_INTERCONNECT_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        req_s = '0;
        we_s  = '0;
        if (state_q == ACCESS) begin
            req_s[sel_q] = 1'b1;
            we_s[sel_q]  = we_q;
        end
    end

    assign ready_m = (state_q == RESP) || (state_q == ERR);
    assign err_m   = (state_q == ERR);
    assign rd_m    = rd_q;
    assign addr_s  = addr_q;
    assign wd_s    = wd_q;
    assign be_s    = be_q;
endmodule

// File: tb/tb_region_interconnect.sv
// Scoreboard bench for region_interconnect: driver predicts responses from the region map, monitor checks them.
// Build with or without +define+REGION_INTERCONNECT_TIMEOUT_EN; expectations follow the macro.
module tb_region_interconnect;
    localparam int unsigned REGIONS = 4;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned NEVER   = 1000;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic [REGIONS*ADDR_W-1:0] region_base = '0;
    logic [REGIONS*ADDR_W-1:0] region_end = '0;
    logic                      req_m = 1'b0;
    logic                      we_m = 1'b0;
    logic [ADDR_W-1:0]         addr_m = '0;
    logic [DATA_W-1:0]         wd_m = '0;
    logic [DATA_W/8-1:0]       be_m = '0;
    logic                      ready_m;
    logic                      err_m;
    logic [DATA_W-1:0]         rd_m;
    logic [REGIONS-1:0]        req_s;
    logic [REGIONS-1:0]        we_s;
    logic [ADDR_W-1:0]         addr_s;
    logic [DATA_W-1:0]         wd_s;
    logic [DATA_W/8-1:0]       be_s;
    logic [REGIONS-1:0]        ack_s = '0;
    logic [REGIONS*DATA_W-1:0] rd_s = '0;

    region_interconnect #(
        .REGIONS(REGIONS),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .region_base(region_base), .region_end(region_end),
        .req_m(req_m), .we_m(we_m), .addr_m(addr_m), .wd_m(wd_m), .be_m(be_m),
        .ready_m(ready_m), .err_m(err_m), .rd_m(rd_m),
        .req_s(req_s), .we_s(we_s), .addr_s(addr_s), .wd_s(wd_s), .be_s(be_s),
        .ack_s(ack_s), .rd_s(rd_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int unsigned cyc;
    } resp_t;

    resp_t        exp_q[$];
    int unsigned  vectors = 0;
    int unsigned  miscompares = 0;
    int unsigned  cyc = 0;
    bit           just_done = 0;
    bit           force_ack = 0;
    logic [31:0]  base_a[4];
    logic [31:0]  end_a[4];

    // Expected slave-side view of the current transaction.
    bit           cur_hit = 0;
    logic [3:0]   cur_oh = '0;
    logic         cur_we = 1'b0;
    logic [31:0]  cur_addr = '0;
    logic [31:0]  cur_wd = '0;
    logic [3:0]   cur_be = '0;
    int unsigned  cur_delay = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int find_region(input logic [31:0] a);
        for (int i = 0; i < 4; i++)
            if (base_a[i] <= a && a < end_a[i]) return i;
        return -1;
    endfunction

    task automatic apply_map();
        for (int i = 0; i < 4; i++) begin
            region_base[i*32 +: 32] = base_a[i];
            region_end[i*32 +: 32]  = end_a[i];
        end
    endtask

    task automatic idle(input int unsigned n);
        req_m = 1'b0;
        just_done = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req_m = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        just_done = 0;
        @(negedge clk);
    endtask

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input int unsigned delay, input logic [31:0] rd_val);
        int          idx;
        resp_t       e;
        int unsigned start;
        bit          exp_resp;
        idx   = find_region(a);
        start = cyc + (just_done ? 1 : 0);
        for (int i = 0; i < 4; i++) rd_s[i*32 +: 32] = $urandom();
        exp_resp = 1;
        cur_hit  = (idx >= 0);
        if (idx >= 0) begin
            rd_s[idx*32 +: 32] = rd_val;
            cur_oh    = 4'b0001 << idx;
            cur_we    = we;
            cur_addr  = a - base_a[idx];
            cur_wd    = wd;
            cur_be    = be;
            cur_delay = delay;
            e.err = 1'b0;
            e.rd  = we ? 32'h0 : rd_val;
            e.cyc = start + 2 + delay;
`ifdef REGION_INTERCONNECT_TIMEOUT_EN
            if (delay >= TIMEOUT) begin
                e.err = 1'b1;
                e.rd  = 32'h0;
                e.cyc = start + 1 + TIMEOUT;
            end
`else
            if (delay == NEVER) exp_resp = 0;
`endif
        end else begin
            cur_oh = '0;
            e.err  = 1'b1;
            e.rd   = 32'h0;
            e.cyc  = start + 1;
        end
        if (exp_resp) exp_q.push_back(e);
        req_m = 1'b1; we_m = we; addr_m = a; wd_m = wd; be_m = be;
        just_done = 0;
        if (!exp_resp) begin
            repeat (100) @(negedge clk);
            vectors++;
            if (req_s !== cur_oh || ready_m !== 1'b0) begin
                miscompares++;
                $display("FAIL hang_access req_s=%b ready_m=%b required req_s=%b ready_m=0", req_s, ready_m, cur_oh);
            end
            return;
        end
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ready_m) begin
                just_done = 1;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL txn_timeout addr=%h no ready_m within 200 cycles, required by cycle %0d", a, e.cyc);
    endtask

    // Slave model: checks the broadcast request, acks after cur_delay cycles, sprays junk on other ack bits.
    initial begin
        int unsigned w;
        logic [3:0]  junk;
        w = 0;
        forever begin
            @(posedge clk);
            #2;
            junk = 4'($urandom);
            if (req_s !== '0) begin
                vectors++;
                if (!cur_hit || req_s !== cur_oh || we_s !== (cur_we ? cur_oh : 4'b0000) ||
                    addr_s !== cur_addr || wd_s !== cur_wd || be_s !== cur_be) begin
                    miscompares++;
                    $display("FAIL slave_req req_s=%b we_s=%b addr_s=%h wd_s=%h be_s=%b required hit=%0b req_s=%b we=%b addr=%h wd=%h be=%b",
                             req_s, we_s, addr_s, wd_s, be_s, cur_hit, cur_oh, cur_we, cur_addr, cur_wd, cur_be);
                end
                ack_s = ((w == cur_delay) ? cur_oh : 4'b0000) | (junk & ~cur_oh);
                w++;
            end else begin
                w = 0;
                ack_s = junk;
            end
            if (force_ack) ack_s = '1;
        end
    end

    // Monitor: every ready_m pulse must match the oldest predicted response, including its cycle.
    initial begin
        resp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (ready_m === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_ready cyc=%0d err_m=%b rd_m=%h required no ready_m", cyc, err_m, rd_m);
                end else begin
                    e = exp_q.pop_front();
                    if (err_m !== e.err || rd_m !== e.rd || cyc != e.cyc) begin
                        miscompares++;
                        $display("FAIL response err_m=%b rd_m=%h cyc=%0d required err_m=%b rd_m=%h cyc=%0d",
                                 err_m, rd_m, cyc, e.err, e.rd, e.cyc);
                    end
                end
            end else if (err_m !== 1'b0) begin
                vectors++;
                miscompares++;
                $display("FAIL err_outside err_m=%b required 0 when ready_m=0", err_m);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] edges[8];
        logic [31:0] a;
        edges = '{32'h0000_0000, 32'h0000_0FFF, 32'h0000_1000, 32'h0000_20FF,
                  32'h0000_2100, 32'h0000_2FFF, 32'h0000_3000, 32'hFFFF_FFFF};
        base_a = '{32'h0000, 32'h1000, 32'h2000, 32'h3000};
        end_a  = '{32'h1000, 32'h2000, 32'h2100, 32'h3000};
        apply_map();

        repeat (2) @(negedge clk);
        vectors++;
        if ({ready_m, err_m, rd_m, req_s, we_s, addr_s, wd_s, be_s} !== '0) begin
            miscompares++;
            $display("FAIL reset_state ready=%b err=%b rd=%h req_s=%b we_s=%b addr_s=%h wd_s=%h be_s=%b required all 0",
                     ready_m, err_m, rd_m, req_s, we_s, addr_s, wd_s, be_s);
        end
        reset = 1'b1;
        idle(2);

        issue(1'b0, 32'h1004, 32'h0, 4'hF, 0, 32'hCAFE_F00D);
        issue(1'b1, 32'h2010, 32'h1234_5678, 4'b0011, 3, $urandom());
        idle(1);
        issue(1'b0, 32'h3000, 32'h0, 4'hF, 0, $urandom());
        issue(1'b0, 32'h5000, 32'h0, 4'hF, 0, $urandom());
        idle(2);

        base_a[0] = 32'h0000; end_a[0] = 32'h2000;
        apply_map();
        issue(1'b0, 32'h1800, 32'h0, 4'hF, 1, $urandom());
        idle(2);
        base_a[0] = 32'h0000; end_a[0] = 32'h1000;
        apply_map();

        // Slave that never acks: timeout error with the macro, indefinite wait without it.
        issue(1'b0, 32'h1008, 32'h0, 4'hF, NEVER, $urandom());
`ifdef REGION_INTERCONNECT_TIMEOUT_EN
        force_ack = 1;
        idle(5);
        force_ack = 0;
        vectors++;
        if (rd_m !== 32'h0) begin
            miscompares++;
            $display("FAIL late_ack rd_m=%h required 0", rd_m);
        end
        issue(1'b0, 32'h0010, 32'h0, 4'hF, TIMEOUT - 1, $urandom());
        issue(1'b0, 32'h0014, 32'h0, 4'hF, TIMEOUT, $urandom());
        idle(2);
`else
        do_reset();
        idle(1);
`endif

        // Reset in the second ACCESS cycle drops the transaction.
        issue(1'b0, 32'h0004, 32'h0, 4'hF, 0, 32'h1111_2222);
        idle(2);
        cur_hit = 1; cur_oh = 4'b0010; cur_we = 1'b1; cur_addr = 32'h20;
        cur_wd = 32'hA5A5_5A5A; cur_be = 4'b1010; cur_delay = NEVER;
        req_m = 1'b1; we_m = 1'b1; addr_m = 32'h1020; wd_m = 32'hA5A5_5A5A; be_m = 4'b1010;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        req_m = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({ready_m, err_m, rd_m, req_s, we_s, addr_s, wd_s, be_s} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_access ready=%b err=%b rd=%h req_s=%b we_s=%b addr_s=%h wd_s=%h be_s=%b required all 0",
                     ready_m, err_m, rd_m, req_s, we_s, addr_s, wd_s, be_s);
        end
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        issue(1'b0, 32'h0004, 32'h0, 4'hF, 0, $urandom());
        idle(1);

        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 5))
                0:       a = 32'($urandom_range(0, 32'hFFF));
                1:       a = 32'h1000 + 32'($urandom_range(0, 32'hFFF));
                2:       a = 32'h2000 + 32'($urandom_range(0, 32'hFF));
                3, 4:    a = edges[$urandom_range(0, 7)];
                default: a = $urandom();
            endcase
            issue(1'($urandom()), a, $urandom(), 4'($urandom()), $urandom_range(0, 4), $urandom());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        idle(4);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL leftover_responses %0d predicted responses never seen, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
